udma_stream_packer: RTL and testbench
=====================================

// Module: udma_stream_packer
// PURPOSE
// Downstream stage of the uDMA stream unit: consumes its out_stream beats (byte/half/word, sot/eot framed) and
// packs them little-endian into full 32-bit words for an RX channel. Residue at end-of-transfer is flushed as
// halfword/byte beats, so the RX channel sees the fewest beats for the exact byte count. cfg_en_i=0 is pure bypass.
// PARAMETERS
// DATA_WIDTH   32   stream/channel data width; only 32 supported
// PORTS
// clk_i                 in   1   clock
// rstn_i                in   1   reset, asynchronous, active-low
// clr_i                 in   1   synchronous clear (uDMA cmd clear)
// cfg_en_i              in   1   1=pack, 0=bypass in_stream_* -> rx_ch_* combinationally
// in_stream_data_i      in   32  payload, valid bytes in low lanes
// in_stream_datasize_i  in   2   00=1B 01=2B 10=4B 11=illegal
// in_stream_valid_i     in   1   beat valid
// in_stream_sot_i       in   1   first beat of transfer
// in_stream_eot_i       in   1   last beat of transfer
// in_stream_ready_o     out  1   beat accepted when valid&ready
// rx_ch_data_o          out  32  packed data, valid bytes in low lanes
// rx_ch_datasize_o      out  2   00/01/10 as input encoding
// rx_ch_valid_o         out  1   output beat valid
// rx_ch_ready_i         in   1   RX channel accepts beat
// err_o                 out  1   sticky error; cleared by clr_i
// busy_o                out  1   state!=ST_FILL or r_cnt!=0
// BEHAVIOUR
// - Reset/clr_i: r_buf=0 (64b), r_cnt=0 (0..7 bytes), state ST_FILL, err_o=0; outputs: ready=1 (if cfg_en_i), valid=0,
//   data=0, datasize=0, busy=0. clr_i wins over any simultaneous handshake; residue discarded.
// - Bypass (cfg_en_i=0): all rx_ch_* = in_stream_*, ready = rx_ch_ready_i; packer state frozen. Toggle cfg_en_i only when busy_o=0.
// - n_in = 1/2/4 per datasize. n_out = 4 if r_cnt>=4; in ST_FLUSH: 2 if r_cnt in 2..3, 1 if r_cnt==1.
// - rx_ch_valid_o = (r_cnt>=4) | (ST_FLUSH & r_cnt!=0); rx_ch_data_o = r_buf[31:0]; datasize from n_out.
// - Output is registered: a beat accepted in cycle N appears on rx_ch_* no earlier than N+1.
// - ST_FILL: in_stream_ready_o = (r_cnt<4) | rx_ch_ready_i. Same-cycle pop and push legal: pop shifts r_buf right by
//   n_out bytes, push writes n_in bytes at byte offset (r_cnt - pop_bytes); r_cnt_next = r_cnt - pop_bytes + n_in (<=7).
//   Sustained word stream at count 0 runs 1 word/cycle with rx_ch_ready_i=1.
// - Accepted beat with eot: if r_cnt_next==0 stay ST_FILL, else -> ST_FLUSH.
// - ST_FLUSH: in_stream_ready_o=0; emit word, then half, then byte until r_cnt==0, then -> ST_FILL.
//   e.g. 7 residue bytes -> word, half, byte (3 beats).
// - sot accepted while r_cnt!=0 (missing eot): residue dropped, err_o set, new beat packed from offset 0.
// - datasize 11: beat accepted and dropped (n_in=0), err_o set; eot on it still triggers flush.
// - Backpressure: rx_ch_* held stable while valid & !ready.
// STRUCTURE
// - udma_pkg gains: typedef enum logic[1:0] {DS_BYTE,DS_HALF,DS_WORD} udma_dsize_e; function ds2bytes().
// - Local enum {ST_FILL,ST_FLUSH}. One sub-module natural: udma_byte_shifter (64b buffer, byte-granular
//   shift-right by pop count and insert at offset); rest is control in this file.
// TESTING
// - 4 byte beats 0x11,0x22,0x33,0x44 (sot on 1st, eot on 4th), ready=1 -> one beat 0x44332211 size 10, no flush beat.
// - word 0xAABBCCDD every cycle x8, ready=1 -> 8 words out, in_stream_ready_o never low, 1 cycle latency.
// - byte 0x01, half 0x0302, word 0x07060504 eot -> 0x04030201 size 10, half 0x0605, byte 0x07; ready low in flush.
// - rx_ch_ready_i=0 for 5 cycles with r_cnt=7 -> in_stream_ready_o=0, rx_ch_data_o stable; release -> drains 7 bytes.
// - datasize 11 beat and sot-without-eot -> err_o=1 sticky; clr_i mid-flush -> valid=0, r_cnt=0, err_o=0 next cycle.
// - cfg_en_i=0: byte beat with eot -> identical beat on rx_ch_* same cycle, ready follows rx_ch_ready_i.

Source files
------------

// File: rtl/udma_stream_packer_pkg.sv
// Shared types and helpers for the uDMA stream packer: datasize encoding and
// conversions between the 2-bit datasize code and a byte count.
package udma_stream_packer_pkg;

  typedef enum logic [1:0] {
    DS_BYTE = 2'b00,
    DS_HALF = 2'b01,
    DS_WORD = 2'b10
  } udma_dsize_e;

  localparam int BUF_BYTES = 8;

  // The reserved code 2'b11 maps to zero bytes so that such a beat carries no payload.
  function automatic logic [2:0] ds2bytes(input logic [1:0] ds);
    logic [2:0] n;
    case (ds)
      DS_BYTE: n = 3'd1;
      DS_HALF: n = 3'd2;
      DS_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] bytes2ds(input logic [2:0] n);
    logic [1:0] ds;
    case (n)
      3'd4:    ds = DS_WORD;
      3'd2:    ds = DS_HALF;
      default: ds = DS_BYTE;
    endcase
    return ds;
  endfunction

endpackage

// File: rtl/udma_stream_packer_byte_shifter.sv
// 8-byte packing buffer datapath: drops popped bytes from the bottom, keeps the
// next keep_cnt bytes, and writes ins_bytes of ins_data directly above them.
module udma_stream_packer_byte_shifter
  import udma_stream_packer_pkg::*;
(
  input  logic [63:0] buf_cur,
  input  logic [2:0]  pop_bytes,
  input  logic [2:0]  keep_cnt,
  input  logic [31:0] ins_data,
  input  logic [2:0]  ins_bytes,
  output logic [63:0] buf_new
);

  logic [63:0] shifted;
  logic [3:0]  ins_end;

  assign shifted = buf_cur >> {pop_bytes, 3'b000};
  assign ins_end = {1'b0, keep_cnt} + {1'b0, ins_bytes};

  // Lanes above the live data are forced to zero, so stale bytes never leak out.
  generate
    for (genvar gi = 0; gi < BUF_BYTES; gi++) begin : g_lane
      logic       is_kept;
      logic       is_ins;
      logic [1:0] rel;

      assign is_kept = (3'(gi) < keep_cnt);
      assign is_ins  = (4'(gi) >= {1'b0, keep_cnt}) && (4'(gi) < ins_end);
      assign rel     = 2'(gi) - keep_cnt[1:0];

      assign buf_new[gi*8 +: 8] = is_kept ? shifted[gi*8 +: 8] :
                                  is_ins  ? ins_data[{rel, 3'b000} +: 8] :
                                            8'h00;
    end
  endgenerate

endmodule

// File: rtl/udma_stream_packer.sv
// Packs uDMA stream beats (byte/half/word) little-endian into 32-bit words for an
// RX channel, flushing end-of-transfer residue as halfword/byte beats.
module udma_stream_packer
  import udma_stream_packer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clr_i,
  input  logic                  cfg_en_i,
  input  logic [DATA_WIDTH-1:0] in_stream_data_i,
  input  logic [1:0]            in_stream_datasize_i,
  input  logic                  in_stream_valid_i,
  input  logic                  in_stream_sot_i,
  input  logic                  in_stream_eot_i,
  output logic                  in_stream_ready_o,
  output logic [DATA_WIDTH-1:0] rx_ch_data_o,
  output logic [1:0]            rx_ch_datasize_o,
  output logic                  rx_ch_valid_o,
  input  logic                  rx_ch_ready_i,
  output logic                  err_o,
  output logic                  busy_o
);

  typedef enum logic {ST_FILL, ST_FLUSH} state_e;

  state_e      state_reg, state_next;
  logic [63:0] buf_reg, buf_next, buf_shift;
  logic [2:0]  cnt_reg, cnt_next;
  logic        err_reg, err_next;

  logic [2:0]  n_out, n_in, pop_bytes, keep_cnt;
  logic        pk_valid, pk_ready, pop, push, drop, bad_ds;

  // A full word leaves whenever available; partial beats only while flushing.
  always_comb begin
    n_out = 3'd0;
    if (cnt_reg >= 3'd4) begin
      n_out = 3'd4;
    end else if (state_reg == ST_FLUSH) begin
      n_out = (cnt_reg >= 3'd2) ? 3'd2 : cnt_reg;
    end
  end

  assign pk_valid  = (n_out != 3'd0);
  assign pk_ready  = (state_reg == ST_FILL) && ((cnt_reg < 3'd4) || rx_ch_ready_i);
  assign pop       = cfg_en_i && pk_valid && rx_ch_ready_i;
  assign push      = cfg_en_i && in_stream_valid_i && pk_ready;
  assign bad_ds    = (in_stream_datasize_i == 2'b11);
  assign drop      = push && in_stream_sot_i && (cnt_reg != 3'd0);
  assign pop_bytes = pop ? n_out : 3'd0;
  assign n_in      = push ? ds2bytes(in_stream_datasize_i) : 3'd0;
  assign keep_cnt  = drop ? 3'd0 : (cnt_reg - pop_bytes);

  udma_stream_packer_byte_shifter u_shifter (
    .buf_cur   (buf_reg),
    .pop_bytes (pop_bytes),
    .keep_cnt  (keep_cnt),
    .ins_data  (in_stream_data_i[31:0]),
    .ins_bytes (n_in),
    .buf_new   (buf_shift)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    buf_next   = buf_reg;
    err_next   = err_reg;
    if (cfg_en_i) begin
      cnt_next = keep_cnt + n_in;
      buf_next = buf_shift;
      err_next = err_reg | (push & (bad_ds | drop));
      case (state_reg)
        ST_FILL: begin
          if (push && in_stream_eot_i && (cnt_next != 3'd0)) begin
            state_next = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (cnt_next == 3'd0) begin
            state_next = ST_FILL;
          end
        end
        default: state_next = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg <= ST_FILL;
      cnt_reg   <= 3'd0;
      buf_reg   <= 64'd0;
      err_reg   <= 1'b0;
    end else if (clr_i) begin
      state_reg <= ST_FILL;
      cnt_reg   <= 3'd0;
      buf_reg   <= 64'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      buf_reg   <= buf_next;
      err_reg   <= err_next;
    end
  end

  // Bypass is purely combinational; the packer state is left untouched.
  assign rx_ch_data_o      = cfg_en_i ? buf_reg[DATA_WIDTH-1:0] : in_stream_data_i;
  assign rx_ch_datasize_o  = cfg_en_i ? bytes2ds(n_out) : in_stream_datasize_i;
  assign rx_ch_valid_o     = cfg_en_i ? pk_valid : in_stream_valid_i;
  assign in_stream_ready_o = cfg_en_i ? pk_ready : rx_ch_ready_i;
  assign err_o             = err_reg;
  assign busy_o            = (state_reg != ST_FILL) || (cnt_reg != 3'd0);

endmodule

// File: tb/tb_udma_stream_packer.sv
// Self-checking bench for udma_stream_packer: a byte-queue reference model feeds a
// scoreboard that a free-running monitor drains on every RX handshake.
module tb_udma_stream_packer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clr = 1'b0;
  logic        cfg_en = 1'b1;
  logic [31:0] in_data = '0;
  logic [1:0]  in_ds = '0;
  logic        in_valid = 1'b0;
  logic        in_sot = 1'b0;
  logic        in_eot = 1'b0;
  logic        in_ready;
  logic [31:0] rx_data;
  logic [1:0]  rx_ds;
  logic        rx_valid;
  wire         rx_ready;
  logic        err;
  logic        busy;

  logic        rdy_man = 1'b1;
  logic        rand_rdy = 1'b0;
  logic        rand_bit = 1'b1;

  assign rx_ready = rand_rdy ? rand_bit : rdy_man;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  ds;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] pend[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  udma_stream_packer #(.DATA_WIDTH(32)) dut (
    .clk_i                (clk),
    .rstn_i               (rstn),
    .clr_i                (clr),
    .cfg_en_i             (cfg_en),
    .in_stream_data_i     (in_data),
    .in_stream_datasize_i (in_ds),
    .in_stream_valid_i    (in_valid),
    .in_stream_sot_i      (in_sot),
    .in_stream_eot_i      (in_eot),
    .in_stream_ready_o    (in_ready),
    .rx_ch_data_o         (rx_data),
    .rx_ch_datasize_o     (rx_ds),
    .rx_ch_valid_o        (rx_valid),
    .rx_ch_ready_i        (rx_ready),
    .err_o                (err),
    .busy_o               (busy)
  );

  function automatic logic [31:0] ds_mask(input logic [1:0] ds);
    return (ds == 2'b00) ? 32'h0000_00ff : (ds == 2'b01) ? 32'h0000_ffff : 32'hffff_ffff;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Reference: bytes accumulate per transfer; every 4 form a word, eot residue leaves as half then byte.
  task automatic model_accept(input logic [31:0] d, input logic [1:0] ds, input logic sot, input logic eot);
    int n;
    n = (ds == 2'b00) ? 1 : (ds == 2'b01) ? 2 : (ds == 2'b10) ? 4 : 0;
    if (sot) pend.delete();
    for (int i = 0; i < n; i++) pend.push_back(d[8*i +: 8]);
    while (pend.size() >= 4) begin
      exp_q.push_back('{d: {pend[3], pend[2], pend[1], pend[0]}, ds: 2'b10});
      repeat (4) void'(pend.pop_front());
    end
    if (eot) begin
      if (pend.size() >= 2) begin
        exp_q.push_back('{d: {16'h0, pend[1], pend[0]}, ds: 2'b01});
        repeat (2) void'(pend.pop_front());
      end
      if (pend.size() == 1) begin
        exp_q.push_back('{d: {24'h0, pend[0]}, ds: 2'b00});
        void'(pend.pop_front());
      end
    end
  endtask

  task automatic monitor();
    beat_t e;
    forever begin
      @(negedge clk);
      if (rstn && rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %h size %0d, expected no beat", rx_data, rx_ds);
        end else begin
          e = exp_q.pop_front();
          check("out_size", {30'h0, rx_ds}, {30'h0, e.ds});
          check("out_data", rx_data & ds_mask(e.ds), e.d & ds_mask(e.ds));
        end
      end
    end
  endtask

  // Drives one beat starting at posedge+1 and returns at posedge+1 after acceptance.
  task automatic send_beat(input logic [31:0] d, input logic [1:0] ds, input logic sot,
                           input logic eot, output int waited);
    logic acc;
    acc = 1'b0;
    waited = 0;
    in_data = d; in_ds = ds; in_sot = sot; in_eot = eot; in_valid = 1'b1;
    if (!cfg_en) exp_q.push_back('{d: d, ds: ds});
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) begin
        waited++;
        if (waited > 300) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: beat %h not accepted after %0d cycles", d, waited);
          break;
        end
      end
    end
    in_valid = 1'b0; in_sot = 1'b0; in_eot = 1'b0;
    if (acc && cfg_en) model_accept(d, ds, sot, eot);
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
    @(negedge clk);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_busy", {31'h0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int wsum;
    int nb;

    fork
      monitor();
      forever begin
        @(posedge clk);
        #1;
        rand_bit = ($urandom_range(0, 9) < 7);
      end
      begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_valid", {31'h0, rx_valid}, 32'd0);
    check("rst_data", rx_data, 32'd0);
    check("rst_size", {30'h0, rx_ds}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_err", {31'h0, err}, 32'd0);
    check("rst_ready", {31'h0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Four bytes make exactly one word.
    send_beat(32'h11, 2'b00, 1'b1, 1'b0, w);
    send_beat(32'h22, 2'b00, 1'b0, 1'b0, w);
    send_beat(32'h33, 2'b00, 1'b0, 1'b0, w);
    send_beat(32'h44, 2'b00, 1'b0, 1'b1, w);
    drain();

    // Back-to-back words at full rate.
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      send_beat(32'hAABBCCDD, 2'b10, i == 0, i == 7, w);
      wsum += w;
    end
    check("burst_stalls", 32'(wsum), 32'd0);
    @(negedge clk);
    check("burst_last_valid", {31'h0, rx_valid}, 32'd1);
    check("burst_last_data", rx_data, 32'hAABBCCDD);
    @(negedge clk);
    check("burst_empty", {31'h0, rx_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Mixed sizes, 7 bytes: word, half, byte; input blocked while flushing.
    send_beat(32'h01, 2'b00, 1'b1, 1'b0, w);
    send_beat(32'h0302, 2'b01, 1'b0, 1'b0, w);
    send_beat(32'h07060504, 2'b10, 1'b0, 1'b1, w);
    @(negedge clk);
    check("flush_ready_low", {31'h0, in_ready}, 32'd0);
    check("flush_busy", {31'h0, busy}, 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Backpressure with 7 buffered bytes.
    rdy_man = 1'b0;
    send_beat(32'h01, 2'b00, 1'b1, 1'b0, w);
    send_beat(32'h0302, 2'b01, 1'b0, 1'b0, w);
    send_beat(32'h07060504, 2'b10, 1'b0, 1'b1, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_ready", {31'h0, in_ready}, 32'd0);
      check("stall_valid", {31'h0, rx_valid}, 32'd1);
      check("stall_data", rx_data, 32'h04030201);
      check("stall_size", {30'h0, rx_ds}, 32'd2);
    end
    @(posedge clk);
    #1 rdy_man = 1'b1;
    drain();

    // Illegal datasize sets the sticky error; clr removes it.
    send_beat(32'hDEADBEEF, 2'b11, 1'b1, 1'b1, w);
    @(negedge clk);
    check("illegal_err", {31'h0, err}, 32'd1);
    check("illegal_busy", {31'h0, busy}, 32'd0);
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("clr_err", {31'h0, err}, 32'd0);
    @(posedge clk);
    #1;

    // sot without preceding eot drops the residue.
    send_beat(32'hA1, 2'b00, 1'b1, 1'b0, w);
    send_beat(32'hB2, 2'b00, 1'b1, 1'b0, w);
    send_beat(32'hC3, 2'b00, 1'b0, 1'b1, w);
    @(negedge clk);
    check("sot_err", {31'h0, err}, 32'd1);
    @(posedge clk);
    #1;
    drain();

    // clr in the middle of a stalled flush.
    rdy_man = 1'b0;
    send_beat(32'h01, 2'b00, 1'b1, 1'b0, w);
    send_beat(32'h0302, 2'b01, 1'b0, 1'b0, w);
    send_beat(32'h07060504, 2'b10, 1'b0, 1'b1, w);
    @(negedge clk);
    check("preclr_valid", {31'h0, rx_valid}, 32'd1);
    @(posedge clk);
    #1 clr = 1'b1;
    exp_q.delete();
    pend.delete();
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("clr_valid", {31'h0, rx_valid}, 32'd0);
    check("clr_busy", {31'h0, busy}, 32'd0);
    check("clr_err_flush", {31'h0, err}, 32'd0);
    check("clr_ready", {31'h0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rdy_man = 1'b1;
    drain();

    // Bypass: combinational pass-through.
    cfg_en = 1'b0;
    in_data = 32'h5A; in_ds = 2'b00; in_sot = 1'b1; in_eot = 1'b1; in_valid = 1'b1;
    exp_q.push_back('{d: 32'h5A, ds: 2'b00});
    @(negedge clk);
    check("byp_valid", {31'h0, rx_valid}, 32'd1);
    check("byp_data", rx_data, 32'h0000005A);
    check("byp_size", {30'h0, rx_ds}, 32'd0);
    check("byp_ready", {31'h0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0; in_sot = 1'b0; in_eot = 1'b0; rdy_man = 1'b0;
    @(negedge clk);
    check("byp_ready_low", {31'h0, in_ready}, 32'd0);
    check("byp_busy", {31'h0, busy}, 32'd0);
    @(posedge clk);
    #1 rdy_man = 1'b1; cfg_en = 1'b1;

    // Randomised transfers with random RX backpressure and idle gaps.
    rand_rdy = 1'b1;
    for (int t = 0; t < 40; t++) begin
      nb = $urandom_range(1, 8);
      for (int b = 0; b < nb; b++) begin
        send_beat($urandom, 2'($urandom_range(0, 2)), b == 0, b == nb - 1, w);
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
      end
    end
    drain();
    rand_rdy = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
